// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: framebuffer pixel fetch and colour stage behind vga_sync_gen.
// Latency: RAM_LAT+2 clocks for colour, o_hs, o_vs and o_de alike.
// Backpressure: none; streams one pixel per clock in the pixel clock domain.
//
// Ports:
//   i_clk, i_rst            pixel clock, synchronous active-high reset
//   i_de, i_hs, i_vs        timing from the sync generator (syncs active low)
//   i_px, i_py              scaled pixel coordinates
//   o_fb_addr, o_fb_rd      framebuffer read address and strobe
//   i_fb_data               read data, valid RAM_LAT clocks after o_fb_rd
//   i_border                border colour {R,G,B}, sampled in the colour stage
//   i_pal_we/idx/rgb        palette write port (PALETTE_EN builds only)
//   o_r, o_g, o_b           4-bit colour outputs
//   o_hs, o_vs, o_de        syncs and display enable, delayed to match colour
//
// Build option: define PALETTE_EN for a 16-entry 12-bit palette lookup;
// without it pixels are expanded as RGB332 and the palette port is ignored.

module vga_fb_scanout #(
    parameter int FB_W_LOG2 = 9,
    parameter int FB_H      = 256,
    parameter int FB_AW     = 17,
    parameter int RAM_LAT   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_de,
    input  logic             i_hs,
    input  logic             i_vs,
    input  logic [10:0]      i_px,
    input  logic [10:0]      i_py,
    output logic [FB_AW-1:0] o_fb_addr,
    output logic             o_fb_rd,
    input  logic [7:0]       i_fb_data,
    input  logic [11:0]      i_border,
    input  logic             i_pal_we,
    input  logic [3:0]       i_pal_idx,
    input  logic [11:0]      i_pal_rgb,
    output logic [3:0]       o_r,
    output logic [3:0]       o_g,
    output logic [3:0]       o_b,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_de
);

    // Total latency; the output registers form the last stage, so the
    // side-band delay line itself is one entry shorter.
    localparam int LAT = RAM_LAT + 2;
    localparam int DL  = LAT - 1;

    // Compare limits widened by one bit so a 2048-pixel-wide buffer still fits.
    localparam logic [11:0] PX_LIM = 12'(1 << FB_W_LOG2);
    localparam logic [11:0] PY_LIM = 12'(FB_H);

    logic             in_bounds;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic             fb_rd_q, fb_rd_d;

    // Side-band delay line; bit 0 is newest, bit DL-1 lines up with RAM data.
    logic [DL-1:0]    de_q, de_d;
    logic [DL-1:0]    hs_q, hs_d;
    logic [DL-1:0]    vs_q, vs_d;
    logic [DL-1:0]    inb_q, inb_d;

    logic [11:0]      pix_rgb;
    logic [11:0]      rgb_q, rgb_d;
    logic             de_o_q, de_o_d;
    logic             hs_o_q, hs_o_d;
    logic             vs_o_q, vs_o_d;

    // ------------------------------------------------------------------
    // Pixel colour from RAM data
    // ------------------------------------------------------------------
`ifdef PALETTE_EN
    logic [11:0] pal_q [16];

    // Reset loads a grey ramp. A write lands at the clock edge, so a lookup
    // registered at that same edge still sees the old entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= {3{4'(i)}};
            end
        end else if (i_pal_we) begin
            pal_q[i_pal_idx] <= i_pal_rgb;
        end
    end

    assign pix_rgb = pal_q[i_fb_data[3:0]];

    // Upper nibble carries no colour information with a 16-entry palette.
    logic unused_data_hi;
    assign unused_data_hi = ^i_fb_data[7:4];
`else
    // RGB332 expansion: replicate MSBs so full scale maps to 4'hF.
    assign pix_rgb = {i_fb_data[7:5], i_fb_data[7],
                      i_fb_data[4:2], i_fb_data[4],
                      i_fb_data[1:0], i_fb_data[1:0]};

    logic unused_pal;
    assign unused_pal = ^{i_pal_we, i_pal_idx, i_pal_rgb};
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        in_bounds = ({1'b0, i_px} < PX_LIM) && ({1'b0, i_py} < PY_LIM);

        // Address only moves on a real fetch; otherwise it holds so the RAM
        // address bus stays quiet through blanking and border.
        fb_rd_d   = i_de & in_bounds;
        fb_addr_d = fb_addr_q;
        if (fb_rd_d) begin
            fb_addr_d = FB_AW'({i_py, i_px[FB_W_LOG2-1:0]});
        end

        de_d  = {de_q[DL-2:0],  i_de};
        hs_d  = {hs_q[DL-2:0],  i_hs};
        vs_d  = {vs_q[DL-2:0],  i_vs};
        inb_d = {inb_q[DL-2:0], in_bounds};

        de_o_d = de_q[DL-1];
        hs_o_d = hs_q[DL-1];
        vs_o_d = vs_q[DL-1];

        // RAM data is only looked at for a delayed in-bounds, enabled slot.
        // Because reset clears the delay line to de=0, data still in flight
        // from before a reset is dropped here.
        rgb_d = '0;
        if (de_q[DL-1]) begin
            if (inb_q[DL-1]) begin
                rgb_d = pix_rgb;
            end else begin
                rgb_d = i_border;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fb_addr_q <= '0;
            fb_rd_q   <= 1'b0;
            de_q      <= '0;
            hs_q      <= '1;
            vs_q      <= '1;
            inb_q     <= '0;
            rgb_q     <= '0;
            de_o_q    <= 1'b0;
            hs_o_q    <= 1'b1;
            vs_o_q    <= 1'b1;
        end else begin
            fb_addr_q <= fb_addr_d;
            fb_rd_q   <= fb_rd_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            inb_q     <= inb_d;
            rgb_q     <= rgb_d;
            de_o_q    <= de_o_d;
            hs_o_q    <= hs_o_d;
            vs_o_q    <= vs_o_d;
        end
    end

    assign o_fb_addr = fb_addr_q;
    assign o_fb_rd   = fb_rd_q;
    assign o_r       = rgb_q[11:8];
    assign o_g       = rgb_q[7:4];
    assign o_b       = rgb_q[3:0];
    assign o_de      = de_o_q;
    assign o_hs      = hs_o_q;
    assign o_vs      = vs_o_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
module tb_vga_fb_scanout;

    localparam int LA = 3;   // latency of DUT with RAM_LAT=1
    localparam int LB = 5;   // latency of DUT with RAM_LAT=3

    logic        i_clk;
    logic        i_rst;
    logic        i_de, i_hs, i_vs;
    logic [10:0] i_px, i_py;
    logic [11:0] i_border;
    logic        i_pal_we;
    logic [3:0]  i_pal_idx;
    logic [11:0] i_pal_rgb;

    logic [16:0] a_fb_addr, b_fb_addr;
    logic        a_fb_rd, b_fb_rd;
    logic [7:0]  a_fb_data, b_fb_data;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic        a_hs, a_vs, a_de, b_hs, b_vs, b_de;

    vga_fb_scanout #(.FB_W_LOG2(9), .FB_H(256), .FB_AW(17), .RAM_LAT(1)) dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs),
        .i_px(i_px), .i_py(i_py), .o_fb_addr(a_fb_addr), .o_fb_rd(a_fb_rd),
        .i_fb_data(a_fb_data), .i_border(i_border), .i_pal_we(i_pal_we),
        .i_pal_idx(i_pal_idx), .i_pal_rgb(i_pal_rgb), .o_r(a_r), .o_g(a_g),
        .o_b(a_b), .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de));

    vga_fb_scanout #(.FB_W_LOG2(9), .FB_H(256), .FB_AW(17), .RAM_LAT(3)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs),
        .i_px(i_px), .i_py(i_py), .o_fb_addr(b_fb_addr), .o_fb_rd(b_fb_rd),
        .i_fb_data(b_fb_data), .i_border(i_border), .i_pal_we(i_pal_we),
        .i_pal_idx(i_pal_idx), .i_pal_rgb(i_pal_rgb), .o_r(b_r), .o_g(b_g),
        .o_b(b_b), .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de));

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Framebuffer contents; unwritten addresses read as zero.
    logic [7:0] mem [int];

    function automatic logic [7:0] ram_rd(logic [16:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : 8'h00;
    endfunction

    // RAM models: latency 1 and latency 3. Non-read slots return junk.
    logic [7:0] a_ram;
    logic [7:0] b_ram [3];
    always @(posedge i_clk) begin
        a_ram    <= a_fb_rd ? ram_rd(a_fb_addr) : 8'hC3;
        b_ram[0] <= b_fb_rd ? ram_rd(b_fb_addr) : 8'hC3;
        b_ram[1] <= b_ram[0];
        b_ram[2] <= b_ram[1];
    end
    assign a_fb_data = a_ram;
    assign b_fb_data = b_ram[2];

    // Scoreboard
    typedef struct {
        int          due;
        logic [17:0] v;
    } rec_t;

    rec_t qr[$];   // {o_fb_rd, o_fb_addr}, shared by both DUTs
    rec_t qa[$];   // {de, hs, vs, rgb} for dut_a
    rec_t qb[$];   // {de, hs, vs, rgb} for dut_b
    rec_t er, ea, eb;

    int          checks = 0;
    int          fails  = 0;
    logic [16:0] last_addr = '0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (qr.size() > 0 && qr[0].due <= cyc) begin
            er = qr.pop_front();
            if (er.due != cyc) check("rd_sched", cyc, er.due);
            else begin
                check("a_rd_addr", 32'({a_fb_rd, a_fb_addr}), 32'(er.v));
                check("b_rd_addr", 32'({b_fb_rd, b_fb_addr}), 32'(er.v));
            end
        end
        if (qa.size() > 0 && qa[0].due <= cyc) begin
            ea = qa.pop_front();
            if (ea.due != cyc) check("a_sched", cyc, ea.due);
            else check("a_pix", 32'({a_de, a_hs, a_vs, a_r, a_g, a_b}), 32'(ea.v[14:0]));
        end
        if (qb.size() > 0 && qb[0].due <= cyc) begin
            eb = qb.pop_front();
            if (eb.due != cyc) check("b_sched", cyc, eb.due);
            else check("b_pix", 32'({b_de, b_hs, b_vs, b_r, b_g, b_b}), 32'(eb.v[14:0]));
        end
    end

    // Drive one clock of sync-gen inputs and queue the expected responses.
    task automatic step(logic de, logic hs, logic vs, logic [10:0] px, logic [10:0] py,
                        logic [11:0] exp_a, logic [11:0] exp_b);
        rec_t r;
        logic inb;
        i_de = de; i_hs = hs; i_vs = vs; i_px = px; i_py = py;
        inb = (px < 11'd512) && (py < 11'd256);
        r.due = cyc + 1;
        if (de && inb) begin
            last_addr = 17'(py) * 17'd512 + 17'(px);
            r.v = {1'b1, last_addr};
        end else begin
            r.v = {1'b0, last_addr};
        end
        qr.push_back(r);
        r.due = cyc + LA; r.v = {3'b000, de, hs, vs, exp_a}; qa.push_back(r);
        r.due = cyc + LB; r.v = {3'b000, de, hs, vs, exp_b}; qb.push_back(r);
        @(posedge i_clk); #1;
    endtask

    // Visible pixel; expected colour depends on the build.
    task automatic px_step(logic [10:0] px, logic [10:0] py, logic [11:0] e332, logic [11:0] epal);
`ifdef PALETTE_EN
        step(1'b1, 1'b1, 1'b1, px, py, epal, epal);
`else
        step(1'b1, 1'b1, 1'b1, px, py, e332, e332);
`endif
    endtask

    // Reset for ncyc clocks; everything queued past this point is replaced by
    // reset/blank expectations until the pipeline refills.
    task automatic do_reset(int ncyc, logic de);
        rec_t r;
        int   n0;
        n0 = cyc;
        while (qr.size() > 0 && qr[qr.size()-1].due > n0) qr.delete(qr.size()-1);
        while (qa.size() > 0 && qa[qa.size()-1].due > n0) qa.delete(qa.size()-1);
        while (qb.size() > 0 && qb[qb.size()-1].due > n0) qb.delete(qb.size()-1);
        for (int k = 0; k < ncyc; k++) begin
            r.due = n0 + 1 + k; r.v = '0; qr.push_back(r);
        end
        for (int d = n0 + 1; d <= n0 + ncyc + LA - 1; d++) begin
            r.due = d; r.v = {3'b000, 1'b0, 1'b1, 1'b1, 12'h000}; qa.push_back(r);
        end
        for (int d = n0 + 1; d <= n0 + ncyc + LB - 1; d++) begin
            r.due = d; r.v = {3'b000, 1'b0, 1'b1, 1'b1, 12'h000}; qb.push_back(r);
        end
        last_addr = '0;
        i_rst = 1'b1; i_de = de; i_hs = 1'b1; i_vs = 1'b1;
        repeat (ncyc) begin @(posedge i_clk); #1; end
        i_rst = 1'b0;
    endtask

`ifdef PALETTE_EN
    logic [11:0] pal_exp_a [6] = '{12'h777, 12'h777, 12'h777, 12'h123, 12'h123, 12'h123};
    logic [11:0] pal_exp_b [6] = '{12'h777, 12'h123, 12'h123, 12'h123, 12'h123, 12'h123};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

    initial begin
        i_rst = 1'b0; i_de = 1'b0; i_hs = 1'b1; i_vs = 1'b1;
        i_px = '0; i_py = '0; i_border = 12'h0A5;
        i_pal_we = 1'b0; i_pal_idx = '0; i_pal_rgb = '0;
        mem[32'h00405] = 8'hE0;
        mem[32'h00000] = 8'hFF;
        mem[32'h1FFFF] = 8'h5A;
        mem[32'h00664] = 8'h1C;
        mem[32'h00207] = 8'h03;
        mem[32'h00001] = 8'h92;
        mem[32'h00808] = 8'h37;
        @(posedge i_clk); #1;

        // Reset held 3 clocks with display enable high.
        do_reset(3, 1'b1);

        // Fetch and colour map, including the buffer's corner pixels.
        px_step(11'd5,   11'd2,   12'hF00, 12'h000);
        px_step(11'd0,   11'd0,   12'hFFF, 12'hFFF);
        px_step(11'd511, 11'd255, 12'h4DA, 12'hAAA);
        px_step(11'd100, 11'd3,   12'h0F0, 12'hCCC);
        px_step(11'd7,   11'd1,   12'h00F, 12'h333);
        px_step(11'd1,   11'd0,   12'h99A, 12'h222);

        // Border: just past each limit and far out of range.
        step(1'b1, 1'b1, 1'b1, 11'd5,    11'd256,  12'h0A5, 12'h0A5);
        step(1'b1, 1'b1, 1'b1, 11'd512,  11'd0,    12'h0A5, 12'h0A5);
        step(1'b1, 1'b1, 1'b1, 11'd2047, 11'd2047, 12'h0A5, 12'h0A5);
        px_step(11'd5, 11'd2, 12'hF00, 12'h000);

        // Blanking with a 136-clock hsync pulse, then a vsync pulse.
        repeat (4)   step(1'b0, 1'b1, 1'b1, 11'd5, 11'd2, 12'h000, 12'h000);
        repeat (136) step(1'b0, 1'b0, 1'b1, 11'd5, 11'd2, 12'h000, 12'h000);
        repeat (4)   step(1'b0, 1'b1, 1'b1, 11'd5, 11'd2, 12'h000, 12'h000);
        repeat (136) step(1'b0, 1'b1, 1'b0, 11'd5, 11'd2, 12'h000, 12'h000);
        repeat (4)   step(1'b0, 1'b1, 1'b1, 11'd5, 11'd2, 12'h000, 12'h000);

        // Reset in the middle of an in-bounds run; RAM replies still in flight.
        px_step(11'd0, 11'd0, 12'hFFF, 12'hFFF);
        px_step(11'd1, 11'd0, 12'h99A, 12'h222);
        px_step(11'd5, 11'd2, 12'hF00, 12'h000);
        do_reset(2, 1'b1);
        px_step(11'd100, 11'd3, 12'h0F0, 12'hCCC);
        px_step(11'd7,   11'd1, 12'h00F, 12'h333);
        repeat (3) step(1'b0, 1'b1, 1'b1, 11'd0, 11'd0, 12'h000, 12'h000);

`ifdef PALETTE_EN
        // A write issued during reset must not land.
        i_pal_we = 1'b1; i_pal_idx = 4'd7; i_pal_rgb = 12'hFFF;
        do_reset(2, 1'b0);
        i_pal_we = 1'b0;
        step(1'b1, 1'b1, 1'b1, 11'd8, 11'd4, 12'h777, 12'h777);
        // Write pal[7] during a run of lookups of entry 7.
        for (int k = 0; k < 6; k++) begin
            i_pal_we  = (k == 4);
            i_pal_rgb = 12'h123;
            step(1'b1, 1'b1, 1'b1, 11'd8, 11'd4, pal_exp_a[k], pal_exp_b[k]);
        end
        i_pal_we = 1'b0;
        repeat (3) step(1'b0, 1'b1, 1'b1, 11'd0, 11'd0, 12'h000, 12'h000);
`endif

        // Let the scoreboard drain.
        repeat (LB + 3) begin @(posedge i_clk); #1; end
        check("drain", 32'(qr.size() + qa.size() + qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
